// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment capture path.
//   - SEG_* : active-low segment patterns (bit0 = a .. bit6 = g, 0 = lit),
//             also used by the display-driver side.
//   - CODE_BLANK / CODE_ERR : decoded codes for a dark digit / unknown pattern.
//   - cap_state_e : capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    SETTLE   = 2'd0,
    PRESENT  = 2'd1,
    WAIT_CHG = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: combinational decode of one active-low 7-segment pattern.
//   i_pat  [6:0] : segment pattern (bit0 = a .. bit6 = g)
//   o_code [3:0] : 0-9, CODE_BLANK for all-dark, CODE_ERR for anything else
//   o_err        : 1 when the pattern is not a digit and not blank
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code,
  output logic       o_err
);

  // Pattern-to-code lookup; unknown patterns (including the 'E' glyph) flag an error.
  always_comb begin
    o_code = CODE_ERR;
    o_err  = 1'b1;
    case (i_pat)
      SEG_0:     begin o_code = 4'd0;       o_err = 1'b0; end
      SEG_1:     begin o_code = 4'd1;       o_err = 1'b0; end
      SEG_2:     begin o_code = 4'd2;       o_err = 1'b0; end
      SEG_3:     begin o_code = 4'd3;       o_err = 1'b0; end
      SEG_4:     begin o_code = 4'd4;       o_err = 1'b0; end
      SEG_5:     begin o_code = 4'd5;       o_err = 1'b0; end
      SEG_6:     begin o_code = 4'd6;       o_err = 1'b0; end
      SEG_7:     begin o_code = 4'd7;       o_err = 1'b0; end
      SEG_8:     begin o_code = 4'd8;       o_err = 1'b0; end
      SEG_9:     begin o_code = 4'd9;       o_err = 1'b0; end
      SEG_BLANK: begin o_code = CODE_BLANK; o_err = 1'b0; end
      default:   begin o_code = CODE_ERR;   o_err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: reads M active-low 7-segment digit buses, waits until they are
// stable for STABLE_CYCLES synced clocks, decodes them and offers the snapshot
// on a valid/ready handshake.
//   CLOCK_50               : clock, all state on rising edge
//   RESET                  : asynchronous active-high reset
//   SEG_IN     [N*M-1:0]   : digit d at [d*N +: N], asynchronous source
//   out_digits [4*M-1:0]   : decoded digit d at [d*4 +: 4]
//   out_err    [M-1:0]     : per-digit unknown-pattern flag
//   out_valid / out_ready  : snapshot handshake
//   snap_count [7:0]       : number of accepted snapshots (wraps)
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int N             = 7,
  parameter int M             = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [N*M-1:0]   SEG_IN,
  output logic [4*M-1:0]   out_digits,
  output logic [M-1:0]     out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       snap_count
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_FIRE = CW'(STABLE_CYCLES - 1);

  logic [N*M-1:0] r_s1;
  logic [N*M-1:0] r_s2;
  logic [N*M-1:0] r_s2_prev;
  logic [N*M-1:0] r_last_pat;
  logic [1:0]     r_fill;
  logic [CW-1:0]  r_cnt;
  cap_state_e     r_state;
  logic [4*M-1:0] r_digits;
  logic [M-1:0]   r_err;
  logic           r_valid;
  logic [7:0]     r_snap_count;

  logic [4*M-1:0] w_code;
  logic [M-1:0]   w_err;
  logic           w_changed;
  logic           w_capture;
  logic           w_accept;
  cap_state_e     w_state_nxt;

  assign w_changed = (r_s2 != r_s2_prev);

  for (genvar d = 0; d < M; d++) begin : g_dec
    seg7_digit_decode u_dec (
      .i_pat  (r_s2[d*N +: N]),
      .o_code (w_code[d*4 +: 4]),
      .o_err  (w_err[d])
    );
  end

  // Two-flop synchroniser plus one-cycle history of s2 for change detection.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_s1      <= {(N*M){1'b1}};
      r_s2      <= {(N*M){1'b1}};
      r_s2_prev <= {(N*M){1'b1}};
      r_fill    <= 2'b00;
    end else begin
      r_s1      <= SEG_IN;
      r_s2      <= r_s1;
      r_s2_prev <= r_s2;
      r_fill    <= {r_fill[0], 1'b1};
    end
  end

  // Stability counter. After reset, s2 holds reset values rather than real
  // samples until two edges have passed, so settling only starts from there.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_cnt <= {CW{1'b0}};
    end else if (!r_fill[1] || w_changed) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Capture FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      SETTLE: begin
        // >= rather than ==: a pattern that settled while a snapshot was still
        // pending leaves the counter saturated, and must still be captured.
        if (!w_changed && (r_cnt >= CNT_FIRE)) begin
          w_capture   = 1'b1;
          w_state_nxt = PRESENT;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      PRESENT: begin
        if (r_valid && out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_CHG;
        end else begin
          w_state_nxt = PRESENT;
        end
      end
      WAIT_CHG: begin
        if (r_s2 != r_last_pat) begin
          w_state_nxt = SETTLE;
        end else begin
          w_state_nxt = WAIT_CHG;
        end
      end
      default: begin
        w_state_nxt = SETTLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= SETTLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Snapshot registers: loaded on capture, held while presented, valid cleared on accept.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_digits     <= {M{CODE_BLANK}};
      r_err        <= {M{1'b0}};
      r_valid      <= 1'b0;
      r_last_pat   <= {(N*M){1'b1}};
      r_snap_count <= 8'd0;
    end else if (w_capture) begin
      r_digits   <= w_code;
      r_err      <= w_err;
      r_valid    <= 1'b1;
      r_last_pat <= r_s2;
    end else if (w_accept) begin
      r_valid      <= 1'b0;
      r_snap_count <= r_snap_count + 8'd1;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_digits = r_digits;
  assign out_err    = r_err;
  assign out_valid  = r_valid;
  assign snap_count = r_snap_count;

endmodule
